// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CSUM_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit fields from a byte stream; shared by header,
// instruction words and checksum, since every field is four bytes long.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  // First byte ends up in bits 7:0 after four shifts toward the LSB.
  assign word_o      = {byte_i, shift_q[31:8]};
  assign word_full_o = valid_i && (cnt_q == 2'(WORD_BYTES - 1));

  // Next-state for the byte counter and shift register
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = 2'd0;
      shift_d = 32'd0;
    end else if (valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_o;
    end else begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
    end
  end

  // Packer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for instruction memory (word-count header, LE words).
// Optional trailing checksum check enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_AFTER_LAST = ST_CSUM;
`else
  localparam loader_state_t ST_AFTER_LAST = ST_DONE;
`endif

  loader_state_t     state_q, state_d;
  logic [31:0]       n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   idx_inc_s;
  logic              accept_s, clr_s, full_s, last_s;
  logic [31:0]       word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  assign rx_ready_o   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign busy_o       = rx_ready_o || (state_q == ST_WRITE);
  assign imem_we_o    = (state_q == ST_WRITE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = (state_q == ST_ERR);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;

  assign accept_s  = rx_valid_i && rx_ready_o;
  assign idx_inc_s = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  // Index is one bit wider than the address so N == 2^ADDR_W terminates cleanly.
  assign last_s    = (32'(idx_inc_s) == n_q);

  byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_s),
    .valid_i     (accept_s),
    .byte_i      (rx_data_i),
    .word_o      (word_s),
    .word_full_o (full_s)
  );

  // Next-state and datapath updates for the load sequencer
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    clr_s   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_HDR;
          clr_s   = 1'b1;
          n_d     = 32'd0;
          idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR: begin
        if (full_s) begin
          n_d = word_s;
          if (word_s == 32'd0) begin
            state_d = ST_AFTER_LAST;
          end else if (word_s > CAPACITY) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (full_s) begin
          wdata_d = word_s;
          addr_d  = idx_q[ADDR_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word_s;
`endif
          state_d = ST_WRITE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        idx_d = idx_inc_s;
        if (last_s) begin
          state_d = ST_AFTER_LAST;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (full_s) begin
          if (word_s == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and write-port registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      n_q     <= 32'd0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=4): vector table plus write scoreboard.
module tb_imem_loader;

  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni, start_i, rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          rx_ready_o, imem_we_o, busy_o, done_o, err_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [31:0] n;
    logic [31:0] w0, w1, w2;
    bit          gaps, smid, timing, use_csum;
    logic [31:0] csum;
  } vec_t;

  wr_t  sb[$];
  int   we_cyc[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && imem_we_o === 1'b1) begin
      we_cyc.push_back(cyc);
      chk("rx_ready_in_write", {31'd0, rx_ready_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", {28'd0, imem_addr_o}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {28'd0, imem_addr_o}, e.addr);
        chk("wr_data", imem_wdata_o, e.data);
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input bit gaps, input bit smid, input bit timing,
                              input bit use_csum, input logic [31:0] csum);
    vec_t v;
    v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2;
    v.gaps = gaps; v.smid = smid; v.timing = timing; v.use_csum = use_csum; v.csum = csum;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid_i = 1'b0;
      rx_data_i  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    t = 0;
    while (rx_ready_o !== 1'b1 && t < 40) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 40) chk("accept_timeout", {31'd0, rx_ready_o}, 32'd1);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic do_load(input vec_t v);
    logic [31:0] words[16];
    logic [31:0] sum, csum;
    bit          exp_err;
    int          nw, t, dcyc;
    for (int i = 0; i < 16; i++) words[i] = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    exp_err = (v.n > 32'd16);
    nw = exp_err ? 0 : int'(v.n);
    sum = 32'd0;
    for (int i = 0; i < nw; i++) sum += words[i];
    csum = v.use_csum ? v.csum : sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!exp_err && csum != sum) exp_err = 1'b1;
`endif
    we_cyc.delete();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("hdr_ready", {31'd0, rx_ready_o}, 32'd1);
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    chk("done_cleared", {30'd0, done_o, err_o}, 32'd0);
    for (int i = 0; i < nw; i++) sb.push_back('{addr: 32'(i), data: words[i]});
    send_word(v.n, v.gaps);
    for (int i = 0; i < nw; i++) begin
      if (v.smid && i == 1) start_i = 1'b1;
      send_word(words[i], v.gaps);
      start_i = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.n <= 32'd16) send_word(csum, v.gaps);
`endif
    t = 0;
    while (!(done_o || err_o) && t < 40) begin
      @(negedge clk_i);
      t++;
    end
    dcyc = cyc;
    chk("done", {31'd0, done_o}, {31'd0, !exp_err});
    chk("err", {31'd0, err_o}, {31'd0, exp_err});
    chk("busy_end", {31'd0, busy_o}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("write_count", 32'(we_cyc.size()), 32'(nw));
    if (v.timing && we_cyc.size() == 3) begin
      chk("we_spacing0", 32'(we_cyc[1] - we_cyc[0]), 32'd5);
      chk("we_spacing1", 32'(we_cyc[2] - we_cyc[1]), 32'd5);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("done_latency", 32'(dcyc - we_cyc[2]), 32'd1);
`endif
    end
    sb.delete();
  endtask

  initial begin
    vec_t post;
    rst_ni = 1'b0; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_outputs", {25'd0, rx_ready_o, imem_we_o, busy_o, done_o, err_o, 2'd0}, 32'd0);
    chk("rst_addr", {28'd0, imem_addr_o}, 32'd0);
    chk("rst_wdata", imem_wdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    vecs.push_back(mk(32'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'h0000_0073, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(32'd2, 32'hDEAD_BEEF, 32'h0102_0304, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk(32'd17, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk(32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk(32'd16, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk(32'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001));
    vecs.push_back(mk(32'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0002));
`endif
    foreach (vecs[i]) do_load(vecs[i]);

    // Reset in the middle of DATA after six bytes (header + two data bytes).
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    send_word(32'd3, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    chk("busy_before_reset", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_outputs", {25'd0, rx_ready_o, imem_we_o, busy_o, done_o, err_o, 2'd0}, 32'd0);
    chk("midrst_addr", {28'd0, imem_addr_o}, 32'd0);
    chk("midrst_wdata", imem_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_after_reset", {30'd0, rx_ready_o, busy_o}, 32'd0);
    post = mk(32'd1, 32'h0000_0013, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    do_load(post);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
